// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: parses the EEPROM program header, forwards in-range
// bytes through a first-word-fall-through FIFO, and requests re-reads at end of program.
module instr_prefetch_queue #(
    parameter int DEPTH        = 8,
    parameter bit AUTO_RESTART = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    input  logic [15:0]                byte_addr,
    output logic                       hold_n,
    output logic                       restart,
    output logic [15:0]                start_addr,
    output logic                       instr_valid,
    output logic [7:0]                 instr_data,
    input  logic                       instr_ready,
    input  logic                       scan_trigger,
    output logic                       scan_done,
    output logic                       hdr_error,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] HOLD_LVL = LW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_HDR, S_SKIP, S_FETCH, S_DRAIN, S_WAIT, S_SYNC, S_ERR
    } state_t;

    state_t          state_q;
    logic [9:0]      start_q, end_q;
    logic            hold_n_q, restart_q, scan_done_q, hdr_error_q, overflow_q, trig_q;
    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;

    logic            addr_is_start, addr_is_end, hdr_bad, trig_rise;
    logic            push_req, push_ok, pop, full;
    logic [9:0]      end_new;

    assign addr_is_start = (byte_addr == {6'b0, start_q});
    assign addr_is_end   = (byte_addr == {6'b0, end_q});
    // The header check has to see the end byte arriving this cycle, not the stale one.
    assign end_new       = {end_q[9:8], byte_data};
    assign hdr_bad       = (start_q < 10'd4) || (end_new == 10'd0) || (end_new < start_q);
    assign trig_rise     = scan_trigger & ~trig_q;

    assign full = (level_q == FULL_LVL);
    assign pop  = (level_q != '0) && instr_ready;

    always_comb begin
        push_req = 1'b0;
        case (state_q)
            S_SKIP, S_SYNC: push_req = byte_valid && addr_is_start;
            S_FETCH:        push_req = byte_valid;
            default:        push_req = 1'b0;
        endcase
    end

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop)
            level_d = level_q + 1'b1;
        else if (!push_ok && pop)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= byte_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HDR;
            start_q     <= '0;
            end_q       <= '0;
            hold_n_q    <= 1'b1;
            restart_q   <= 1'b0;
            scan_done_q <= 1'b0;
            hdr_error_q <= 1'b0;
            overflow_q  <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            restart_q   <= 1'b0;
            scan_done_q <= 1'b0;
            trig_q      <= scan_trigger;
            // One slot of headroom absorbs the byte already in flight when hold drops.
            hold_n_q    <= (level_d < HOLD_LVL);
            if (push_req && full && !pop)
                overflow_q <= 1'b1;
            case (state_q)
                S_HDR: begin
                    if (byte_valid) begin
                        case (byte_addr)
                            16'd0: start_q[9:8] <= byte_data[1:0];
                            16'd1: start_q[7:0] <= byte_data;
                            16'd2: end_q[9:8]   <= byte_data[1:0];
                            16'd3: begin
                                end_q[7:0] <= byte_data;
                                if (hdr_bad) begin
                                    state_q     <= S_ERR;
                                    hdr_error_q <= 1'b1;
                                end else begin
                                    state_q <= S_SKIP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_SKIP, S_SYNC: begin
                    if (byte_valid && addr_is_start)
                        state_q <= (start_q == end_q) ? S_DRAIN : S_FETCH;
                end
                S_FETCH: begin
                    if (byte_valid && addr_is_end)
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && (level_q == LW'(1))) begin
                        scan_done_q <= 1'b1;
                        if (AUTO_RESTART) begin
                            restart_q <= 1'b1;
                            state_q   <= S_SYNC;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (trig_rise) begin
                        restart_q <= 1'b1;
                        state_q   <= S_SYNC;
                    end
                end
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign hold_n      = hold_n_q;
    assign restart     = restart_q;
    assign scan_done   = scan_done_q;
    assign hdr_error   = hdr_error_q;
    assign overflow    = overflow_q;
    assign start_addr  = {6'b0, start_q};
    assign level       = level_q;
    assign instr_valid = (level_q != '0);
    // Gate the head so the empty FIFO presents zero rather than stale storage.
    assign instr_data  = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: one auto-restart instance and one
// trigger-restart instance share the same reader/executor stimulus.
module tb_instr_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [15:0] byte_addr;
    logic        instr_ready;
    logic        scan_trigger;

    logic        hold_n_a, restart_a, instr_valid_a, scan_done_a, hdr_error_a, overflow_a;
    logic [15:0] start_addr_a;
    logic [7:0]  instr_data_a;
    logic [3:0]  level_a;

    logic        hold_n_b, restart_b, instr_valid_b, scan_done_b, hdr_error_b, overflow_b;
    logic [15:0] start_addr_b;
    logic [7:0]  instr_data_b;
    logic [3:0]  level_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(8), .AUTO_RESTART(1'b1)) dut_auto (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_addr(byte_addr), .hold_n(hold_n_a), .restart(restart_a),
        .start_addr(start_addr_a), .instr_valid(instr_valid_a), .instr_data(instr_data_a),
        .instr_ready(instr_ready), .scan_trigger(scan_trigger), .scan_done(scan_done_a),
        .hdr_error(hdr_error_a), .overflow(overflow_a), .level(level_a)
    );

    instr_prefetch_queue #(.DEPTH(8), .AUTO_RESTART(1'b0)) dut_trig (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_addr(byte_addr), .hold_n(hold_n_b), .restart(restart_b),
        .start_addr(start_addr_b), .instr_valid(instr_valid_b), .instr_data(instr_data_b),
        .instr_ready(instr_ready), .scan_trigger(scan_trigger), .scan_done(scan_done_b),
        .hdr_error(hdr_error_b), .overflow(overflow_b), .level(level_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        byte_valid = 1'b1;
        byte_addr  = a;
        byte_data  = d;
        tick();
        byte_valid = 1'b0;
        $display("byte addr=0x%04h data=0x%02h level=%0d valid=%0b head=0x%02h",
                 a, d, level_a, instr_valid_a, instr_data_a);
    endtask

    task automatic send_header(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        send_byte(16'd0, b0);
        send_byte(16'd1, b1);
        send_byte(16'd2, b2);
        send_byte(16'd3, b3);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        byte_valid   = 1'b0;
        byte_data    = 8'h00;
        byte_addr    = 16'h0000;
        instr_ready  = 1'b0;
        scan_trigger = 1'b0;

        // Reset state
        do_reset();
        chk("rst_level",     32'(level_a),       32'd0);
        chk("rst_valid",     32'(instr_valid_a), 32'd0);
        chk("rst_data",      32'(instr_data_a),  32'h00);
        chk("rst_hold_n",    32'(hold_n_a),      32'd1);
        chk("rst_restart",   32'(restart_a),     32'd0);
        chk("rst_scan_done", 32'(scan_done_a),   32'd0);
        chk("rst_hdr_error", 32'(hdr_error_a),   32'd0);
        chk("rst_overflow",  32'(overflow_a),    32'd0);
        chk("rst_start",     32'(start_addr_a),  32'd0);

        // Program 8..10 with a skipped prefix, executor always ready
        instr_ready = 1'b1;
        send_header(8'h00, 8'h08, 8'h00, 8'h0A);
        chk("a_start_addr", 32'(start_addr_a), 32'h0008);
        for (int a = 4; a <= 7; a++) begin
            send_byte(16'(a), 8'(8'h10 + a - 4));
            chk("a_skip_valid", 32'(instr_valid_a), 32'd0);
        end
        for (int a = 8; a <= 10; a++) begin
            send_byte(16'(a), 8'(8'h10 + a - 4));
            chk("a_fetch_valid", 32'(instr_valid_a), 32'd1);
            chk("a_fetch_data",  32'(instr_data_a),  32'(8'h10 + a - 4));
            chk("a_fetch_level", 32'(level_a),       32'd1);
        end
        tick();
        chk("a_scan_done",   32'(scan_done_a), 32'd1);
        chk("a_restart",     32'(restart_a),   32'd1);
        chk("a_drain_level", 32'(level_a),     32'd0);
        chk("a_b_scan_done", 32'(scan_done_b), 32'd1);
        chk("a_b_restart",   32'(restart_b),   32'd0);
        tick();
        chk("a_scan_done_end", 32'(scan_done_a), 32'd0);
        chk("a_restart_end",   32'(restart_a),   32'd0);
        send_byte(16'd11, 8'h21);
        send_byte(16'd12, 8'h22);
        chk("a_sync_discard", 32'(instr_valid_a), 32'd0);
        send_byte(16'd8, 8'h20);
        chk("a_sync_valid",   32'(instr_valid_a), 32'd1);
        chk("a_sync_data",    32'(instr_data_a),  32'h20);
        chk("a_b_wait_valid", 32'(instr_valid_b), 32'd0);

        // Backpressure and overflow with the executor stalled
        do_reset();
        instr_ready = 1'b0;
        send_header(8'h00, 8'h04, 8'h00, 8'h1F);
        for (int i = 0; i < 6; i++)
            send_byte(16'(4 + i), 8'(8'h30 + i));
        chk("b_level6",  32'(level_a),  32'd6);
        chk("b_hold6",   32'(hold_n_a), 32'd1);
        send_byte(16'd10, 8'h36);
        chk("b_level7",  32'(level_a),  32'd7);
        chk("b_hold7",   32'(hold_n_a), 32'd0);
        send_byte(16'd11, 8'h37);
        chk("b_level8",  32'(level_a),    32'd8);
        chk("b_ovf8",    32'(overflow_a), 32'd0);
        send_byte(16'd12, 8'h38);
        chk("b_level9",  32'(level_a),    32'd8);
        chk("b_ovf9",    32'(overflow_a), 32'd1);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b_out_data", 32'(instr_data_a), 32'(8'h30 + i));
            tick();
        end
        chk("b_empty",       32'(level_a),    32'd0);
        chk("b_hold_back",   32'(hold_n_a),   32'd1);
        chk("b_ovf_sticky",  32'(overflow_a), 32'd1);

        // Full-rate push/pop at full level across pointer wrap
        do_reset();
        instr_ready = 1'b0;
        send_header(8'h00, 8'h04, 8'h00, 8'h3F);
        for (int i = 0; i < 8; i++)
            send_byte(16'(4 + i), 8'(8'h40 + i));
        chk("c_full", 32'(level_a), 32'd8);
        instr_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("c_stream_data", 32'(instr_data_a), 32'(8'h40 + j));
            send_byte(16'(12 + j), 8'(8'h48 + j));
            chk("c_stream_level", 32'(level_a), 32'd8);
        end
        chk("c_ovf", 32'(overflow_a), 32'd0);
        for (int j = 16; j < 24; j++) begin
            chk("c_tail_data", 32'(instr_data_a), 32'(8'h40 + j));
            tick();
        end
        chk("c_tail_empty", 32'(instr_valid_a), 32'd0);

        // Bad header: end below start
        do_reset();
        send_header(8'h00, 8'h08, 8'h00, 8'h02);
        chk("d_hdr_error", 32'(hdr_error_a), 32'd1);
        for (int a = 4; a <= 10; a++) begin
            send_byte(16'(a), 8'(8'hE0 + a));
            chk("d_no_valid",   32'(instr_valid_a), 32'd0);
            chk("d_no_restart", 32'(restart_a),     32'd0);
        end
        chk("d_hold_n", 32'(hold_n_a), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("d_hdr_error_clr", 32'(hdr_error_a), 32'd0);

        // Trigger-driven restart, header re-parsed straight after the short reset
        instr_ready = 1'b1;
        send_header(8'h00, 8'h08, 8'h00, 8'h09);
        for (int a = 4; a <= 9; a++)
            send_byte(16'(a), 8'(8'h50 + a));
        chk("e_last_data", 32'(instr_data_b), 32'h59);
        tick();
        chk("e_scan_done",  32'(scan_done_b), 32'd1);
        chk("e_no_restart", 32'(restart_b),   32'd0);
        chk("e_auto_restart", 32'(restart_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("e_wait_restart", 32'(restart_b), 32'd0);
        end
        scan_trigger = 1'b1;
        tick();
        chk("e_trig_restart", 32'(restart_b), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("e_trig_once", 32'(restart_b), 32'd0);
        end
        scan_trigger = 1'b0;
        send_byte(16'd10, 8'h5A);
        send_byte(16'd11, 8'h5B);
        chk("e_stale_discard", 32'(instr_valid_b), 32'd0);
        send_byte(16'd8, 8'h60);
        chk("e_resync_valid", 32'(instr_valid_b), 32'd1);
        chk("e_resync_data",  32'(instr_data_b),  32'h60);

        // Reset mid-fetch with five entries queued
        do_reset();
        instr_ready = 1'b0;
        send_header(8'h00, 8'h04, 8'h00, 8'h1F);
        for (int i = 0; i < 5; i++)
            send_byte(16'(4 + i), 8'(8'h70 + i));
        chk("f_level5", 32'(level_a), 32'd5);
        rst_n = 1'b0;
        tick();
        chk("f_rst_level", 32'(level_a),       32'd0);
        chk("f_rst_valid", 32'(instr_valid_a), 32'd0);
        rst_n = 1'b1;
        send_header(8'h00, 8'h06, 8'h00, 8'h1F);
        send_byte(16'd4, 8'h74);
        send_byte(16'd5, 8'h75);
        chk("f_skip_valid", 32'(instr_valid_a), 32'd0);
        send_byte(16'd6, 8'h77);
        chk("f_new_valid", 32'(instr_valid_a), 32'd1);
        chk("f_new_data",  32'(instr_data_a),  32'h77);
        chk("f_new_start", 32'(start_addr_a),  32'h0006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Sits between the SPI EEPROM byte reader and the stack-machine executor.
- Parses the 4-byte program header (start/end address) and forwards only in-range instruction bytes into a small first-word-fall-through FIFO.
- Presents them to the executor over a valid/ready handshake and applies hold backpressure to the reader.
- At end of program: waits for the FIFO to drain, flags scan completion, and requests a re-read from start_addr (automatically, or on an external trigger).

Parameters:
- DEPTH, 8, FIFO entries; power of two, 4 to 32.
- AUTO_RESTART, 1, 1 = restart immediately after drain; 0 = wait for a scan_trigger rising edge.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- byte_valid  in  1  one-cycle strobe, one per byte delivered by the EEPROM reader.
- byte_data  in  8  byte delivered with byte_valid.
- byte_addr  in  16  EEPROM address of byte_data.
- hold_n  out  1  low = reader must pause.
- restart  out  1  one-cycle pulse: reader re-issues READ at start_addr.
- start_addr  out  16  {6'b0, start[9:0]} from header.
- instr_valid  out  1  FIFO head valid.
- instr_data  out  8  FIFO head byte.
- instr_ready  in  1  executor consumes head when valid&ready.
- scan_trigger  in  1  external scan request; used when AUTO_RESTART=0.
- scan_done  out  1  one-cycle pulse when the last instruction of the program is popped.
- hdr_error  out  1  sticky; set on bad header.
- overflow  out  1  sticky; set when a byte arrives with the FIFO full and no simultaneous pop.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset values:
  - State HDR; FIFO empty, level=0, instr_valid=0, instr_data=0.
  - start=0, end=0.
  - hold_n=1, restart=0, scan_done=0, hdr_error=0, overflow=0.
  - scan_trigger edge register=0.
- rst_n low mid-operation discards FIFO contents and header immediately on that edge.
- States: HDR, SKIP, FETCH, DRAIN, WAIT, SYNC, ERR.
- HDR: on byte_valid, by byte_addr:
  - 0 -> start[9:8] = byte_data[1:0]
  - 1 -> start[7:0]
  - 2 -> end[9:8]
  - 3 -> end[7:0]
  - After addr 3: check end, then go to SKIP.
  - Header check is evaluated on the cycle addr 3 arrives, using the new end byte.
  - Bad header (start<4, end==0, or end<start) -> ERR, hdr_error=1.
- SKIP: ignore bytes with byte_addr<start. The byte with byte_addr==start is pushed and the state goes to FETCH (or DRAIN if start==end).
- FETCH: push every byte_valid byte. The byte with byte_addr==end is pushed, then the state goes to DRAIN.
- Out-of-sequence addresses in FETCH are pushed as-is; the reader guarantees sequence.
- DRAIN: ignore all byte_valid. When the pop of the final entry occurs (level 1->0 via pop), pulse scan_done on the next cycle, then:
  - AUTO_RESTART=1 -> pulse restart in that same cycle and go to SYNC.
  - AUTO_RESTART=0 -> go to WAIT.
- WAIT: on a scan_trigger rising edge (registered, prev=0 & cur=1), pulse restart and go to SYNC.
- SYNC: discard stale in-flight bytes until byte_addr==start, then push that byte and go to FETCH (or DRAIN if start==end). Header is not re-read.
- ERR: no pushes, hold_n=1, restart=0. Only reset exits.
- FIFO:
  - Registered, first-word fall-through.
  - A byte pushed at edge N gives instr_valid=1 after edge N when the FIFO was empty (visible in cycle N+1).
  - Pop occurs when instr_valid & instr_ready. instr_data must be stable while valid & !ready.
  - Push and pop in the same cycle: both occur, level unchanged. Allowed when full.
  - Push when full without a pop: byte dropped, overflow=1.
  - Pointers wrap modulo DEPTH.
- hold_n: registered. It is 0 for the cycle after any edge where next level >= DEPTH-1, otherwise 1. This leaves headroom for one in-flight byte.
- restart and scan_done are exactly one cycle wide and never asserted in the same cycle as reset.

Test Plan:
- Header 00 08 00 0A, then bytes addr 4..10 = 0x10..0x16, instr_ready=1 -> only 0x18?? no: only addr 8,9,10 (0x14,0x15,0x16) appear on instr_data, in order. scan_done pulses one cycle after 0x16 pops. restart pulses the same cycle; start_addr=0x0008.
- DEPTH=8, instr_ready=0, continuous bytes from start -> hold_n falls once level reaches 7. With a forced 9th byte, overflow=1 and level stays 8. Raise ready -> the first 8 bytes exit in order.
- Header with end=0x0002 (< start 0x0008) -> hdr_error=1, instr_valid never asserts, restart never pulses. Assert rst_n=0 for one cycle -> hdr_error=0, state HDR.
- AUTO_RESTART=0, program 8..9 drained -> no restart until scan_trigger goes 0->1. restart then pulses exactly once. Bytes addr 10,11 arriving before addr 8 are discarded.
- Simultaneous push/pop with level=8 -> level stays 8, overflow stays 0, and the output order is preserved across pointer wrap (16+ bytes streamed).
- rst_n low while level=5 in FETCH -> next cycle level=0, instr_valid=0. Header bytes re-parsed from addr 0.
